// File: rtl/flash_ctrl.sv
// Flash controller: accepts one bus request at a time, strobes the flash, settles, polls busy, then responds.
// Optional write-verify read-back is compiled in with FLASH_CTRL_VERIFY_EN.
module flash_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        fl_rd_en,
  output logic        fl_wr_en,
  output logic        fl_erase_en,
  output logic [11:0] fl_addr,
  output logic [31:0] fl_idata,
  input  logic [31:0] fl_odata,
  input  logic        fl_busy,
  input  logic        fl_error
);

  localparam int CW = 16;
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_ER  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    POLL   = 3'd3,
    RESP   = 3'd4
`ifdef FLASH_CTRL_VERIFY_EN
    ,
    VREAD  = 3'd5,
    VCHECK = 3'd6
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            tmo_q, tmo_d;
  logic            rej_q, rej_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            issue_d1_q, issue_d1_d;
  logic            rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d;
  logic            er_en_q, er_en_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic            accept_s;

  assign accept_s = req_valid & req_ready_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    rej_d      = rej_q;
    issue_d1_d = (state_q == ISSUE);

    // Flash read data is valid the cycle after the read strobe
    if (issue_d1_q && (op_q == OP_RD)) begin
      rdata_d = fl_odata;
    end else begin
      rdata_d = rdata_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          rdata_d = 32'h0000_0000;
          cnt_d   = {CW{1'b0}};
          if ((req_op == OP_RSV) || (req_addr[11:10] != 2'b00)) begin
            rej_d   = 1'b1;
            state_d = RESP;
          end else begin
            rej_d   = 1'b0;
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d = {CW{1'b0}};
        if (SETTLE_CYCLES == 0) begin
          state_d = POLL;
        end else begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        err_d = err_q | fl_error;
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = POLL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      POLL: begin
        err_d = err_q | fl_error;
        if (!fl_busy) begin
`ifdef FLASH_CTRL_VERIFY_EN
          if ((op_q == OP_WR) && !(err_q | fl_error)) begin
            state_d = VREAD;
          end else begin
            state_d = RESP;
          end
`else
          state_d = RESP;
`endif
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef FLASH_CTRL_VERIFY_EN
      VREAD: begin
        state_d = VCHECK;
      end
      VCHECK: begin
        if (fl_odata != wdata_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        state_d = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef FLASH_CTRL_VERIFY_EN
    rd_en_d = ((state_d == ISSUE) && (op_d == OP_RD)) || (state_d == VREAD);
`else
    rd_en_d = (state_d == ISSUE) && (op_d == OP_RD);
`endif
    wr_en_d     = (state_d == ISSUE) && (op_d == OP_WR);
    er_en_d     = (state_d == ISSUE) && (op_d == OP_ER);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && (err_d || tmo_d || rej_d);
  end

  // State and output registers; reset clears strobes asynchronously
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      addr_q      <= 12'h000;
      wdata_q     <= 32'h0000_0000;
      cnt_q       <= {CW{1'b0}};
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      rej_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      issue_d1_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      er_en_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      rej_q       <= rej_d;
      rdata_q     <= rdata_d;
      issue_d1_q  <= issue_d1_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      er_en_q     <= er_en_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rsp_err_q;
  assign fl_rd_en    = rd_en_q;
  assign fl_wr_en    = wr_en_q;
  assign fl_erase_en = er_en_q;
  assign fl_addr     = addr_q;
  assign fl_idata    = wdata_q;

endmodule

// File: doc/flash_ctrl.md
FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max cycles spent polling fl_busy before abort.
REQ-002 Parameter SETTLE_CYCLES, default 2: fixed wait cycles after a flash strobe before polling fl_busy.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 Ports SHALL be:
  clk  input  1  rising-edge clock
  nRST  input  1  asynchronous active-low reset
  req_valid  input  1  bus request present
  req_ready  output  1  controller can accept a request
  req_op  input  2  00 read, 01 write, 10 erase, 11 reserved
  req_addr  input  12  word address
  req_wdata  input  32  write data
  rsp_valid  output  1  response present
  rsp_ready  input  1  bus accepts response
  rsp_rdata  output  32  read data
  rsp_err  output  1  operation failed
  fl_rd_en  output  1  flash read strobe
  fl_wr_en  output  1  flash write strobe
  fl_erase_en  output  1  flash erase strobe
  fl_addr  output  12  flash address
  fl_idata  output  32  flash write data
  fl_odata  input  32  flash read data
  fl_busy  input  1  flash busy
  fl_error  input  1  flash error pulse

Function
REQ-005 States SHALL be IDLE, ISSUE, SETTLE, POLL, RESP (plus VREAD, VCHECK when REQ-019 is compiled in).
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid and req_ready both 1, latching op, addr and wdata.
REQ-007 Accepted requests with req_op 11 or req_addr >= 1024 SHALL go directly to RESP with rsp_err 1, rsp_rdata 0, and no flash strobe.
REQ-008 ISSUE SHALL last exactly one cycle, asserting exactly one of fl_rd_en, fl_wr_en or fl_erase_en, per the latched op.
REQ-009 fl_addr and fl_idata SHALL hold the latched values from ISSUE through RESP.
REQ-010 SETTLE SHALL last exactly SETTLE_CYCLES cycles; POLL exits on the first cycle with fl_busy 0.
REQ-011 An error flag SHALL be set by fl_error 1 in any cycle from the cycle after ISSUE through POLL exit, and cleared on request accept.
REQ-012 For reads, fl_odata SHALL be captured into rsp_rdata on the cycle after ISSUE; for write and erase, rsp_rdata SHALL be 0.
REQ-013 If POLL lasts TIMEOUT_CYCLES cycles with fl_busy still 1, the block SHALL enter RESP with rsp_err 1.
REQ-014 RESP SHALL hold rsp_valid 1 with stable rsp_rdata and rsp_err until rsp_ready is 1, then return to IDLE on the next edge.
REQ-015 rsp_err SHALL equal error flag OR timeout OR REQ-007 rejection.
REQ-016 Minimum accept-to-rsp_valid latency for a legal operation with fl_busy never high SHALL be 2 + SETTLE_CYCLES cycles.

Reset
REQ-017 While nRST is 0, the block SHALL be in IDLE with all strobes 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, fl_addr 0, fl_idata 0, and counters 0.
REQ-018 If reset is asserted mid-operation, strobes SHALL drop immediately (asynchronously), any pending response SHALL be discarded, and req_ready SHALL be 1 on the first edge after release.

Configuration
REQ-019 With FLASH_CTRL_VERIFY_EN defined, each successful write SHALL be followed by VREAD (one-cycle fl_rd_en at the same address), then VCHECK one cycle later comparing fl_odata to the latched wdata; a mismatch sets rsp_err 1. Without the macro, writes complete after POLL and no verify read is issued.

Verification
REQ-020 Read addr 0x005 holding 0xDEADBEEF -> one fl_rd_en pulse; rsp_valid after 4 cycles with rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-021 Erase, then write 0x12345678 to 0x010 -> rsp_err 0 for both; a subsequent read returns 0x12345678.
REQ-022 Write to a non-erased word (flash pulses fl_error) -> rsp_err 1; the next read of the same word is unaffected and returns rsp_err 0.
REQ-023 req_addr 0x400 or req_op 11 -> no strobe; rsp_valid on the next cycle with rsp_err 1.
REQ-024 fl_busy held at 1 -> rsp_err 1 after SETTLE_CYCLES + TIMEOUT_CYCLES polling; rsp_ready held 0 for 5 cycles keeps the response stable.
REQ-025 Reset pulse during SETTLE -> strobes 0 and rsp_valid 0; after release, a new read completes normally.
